sha_padder: RTL

SHA_PADDER -- requirements
Module: sha_padder

---
 rtl/sha_padder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sha_padder.sv
// sha_padder: packs a byte stream into big-endian words and appends SHA
// padding (0x80 marker, zero fill, two-word bit length) so that every
// message leaves as a whole number of 16-word blocks.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   tvalid/tready/tlast/tid/tdata   byte input stream, tid taken on first byte
//   ovalid/oready             word output handshake
//   oword                     padded word, first byte in the top lane
//   oidx                      word index within the current block
//   olastblk                  word 15 of the final block of a message
//   oid, olen                 owning message ID, message length in bytes
module sha_padder #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ID_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH  = 61
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    tvalid,
    output logic                    tready,
    input  logic                    tlast,
    input  logic [ID_WIDTH-1:0]     tid,
    input  logic [7:0]              tdata,
    output logic                    ovalid,
    input  logic                    oready,
    output logic [8*WORD_BYTES-1:0] oword,
    output logic [3:0]              oidx,
    output logic                    olastblk,
    output logic [ID_WIDTH-1:0]     oid,
    output logic [LEN_WIDTH-1:0]    olen
);
    localparam int unsigned   WW       = 8 * WORD_BYTES;
    localparam int unsigned   PW       = $clog2(WORD_BYTES);
    localparam logic [PW-1:0] POS_LAST = PW'(WORD_BYTES - 1);
    localparam logic [3:0]    IDX_PAD_END = 4'd13;

    typedef enum logic [1:0] {DATA, ZERO, LEN_HI, LEN_LO} state_e;

    state_e               state_q, state_d;
    logic [WW-1:0]        wbuf_q, wbuf_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [3:0]           widx_q, widx_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic                 first_q, first_d;
    logic                 pad80_q, pad80_d;

    logic                 ovalid_q, ovalid_d;
    logic [WW-1:0]        oword_q, oword_d;
    logic [3:0]           oidx_q, oidx_d;
    logic                 olastblk_q, olastblk_d;
    logic [ID_WIDTH-1:0]  oid_q, oid_d;
    logic [LEN_WIDTH-1:0] olen_q, olen_d;

    logic                 slot_free_c, accept_c, emit_c, lastblk_c;
    logic [WW-1:0]        word_c;
    logic [LEN_WIDTH-1:0] len_out_c;
    logic [2*WW-1:0]      bitlen_c;

    // Output register can take a new word this cycle
    assign slot_free_c = !ovalid_q || oready;
    // Gated by rstn so no byte is accepted while reset is held
    assign tready      = rstn && (state_q == DATA) && slot_free_c;
    assign accept_c    = tvalid && tready;
    assign bitlen_c    = (2*WW)'({len_q, 3'b000});

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= DATA;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DATA: begin
                // Marker fits in the last data word at index 13: go straight to length
                if (accept_c && tlast)
                    state_d = (pos_q != POS_LAST && widx_q == IDX_PAD_END) ? LEN_HI : ZERO;
            end
            ZERO:   if (slot_free_c && widx_q == IDX_PAD_END) state_d = LEN_HI;
            LEN_HI: if (slot_free_c) state_d = LEN_LO;
            LEN_LO: if (slot_free_c) state_d = DATA;
        endcase
    end

    // Datapath and output-word generation
    always_comb begin
        wbuf_d    = wbuf_q;
        pos_d     = pos_q;
        widx_d    = widx_q;
        len_d     = len_q;
        id_d      = id_q;
        first_d   = first_q;
        pad80_d   = pad80_q;
        emit_c    = 1'b0;
        lastblk_c = 1'b0;
        word_c    = '0;
        len_out_c = len_q;

        unique case (state_q)
            DATA: begin
                if (accept_c) begin
                    len_d     = len_q + LEN_WIDTH'(1);
                    len_out_c = len_d;
                    if (first_q) id_d = tid;
                    first_d = 1'b0;
                    word_c  = wbuf_q;
                    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                        if (PW'(b) == pos_q)
                            word_c[8*(WORD_BYTES-1-b) +: 8] = tdata;
                        else if (tlast && pos_q != POS_LAST && PW'(b) == pos_q + PW'(1))
                            word_c[8*(WORD_BYTES-1-b) +: 8] = 8'h80;
                    end
                    if (tlast || pos_q == POS_LAST) begin
                        emit_c = 1'b1;
                        wbuf_d = '0;
                        pos_d  = '0;
                        // Word was full: the marker opens the next word
                        pad80_d = tlast && (pos_q == POS_LAST);
                    end else begin
                        wbuf_d = word_c;
                        pos_d  = pos_q + PW'(1);
                    end
                end
            end
            ZERO: begin
                if (slot_free_c) begin
                    emit_c            = 1'b1;
                    word_c[WW-1 -: 8] = pad80_q ? 8'h80 : 8'h00;
                    pad80_d           = 1'b0;
                end
            end
            LEN_HI: begin
                if (slot_free_c) begin
                    emit_c = 1'b1;
                    word_c = bitlen_c[2*WW-1 -: WW];
                end
            end
            LEN_LO: begin
                if (slot_free_c) begin
                    emit_c    = 1'b1;
                    word_c    = bitlen_c[WW-1:0];
                    lastblk_c = 1'b1;
                    len_d     = '0;
                    first_d   = 1'b1;
                end
            end
        endcase

        if (emit_c) widx_d = lastblk_c ? 4'd0 : widx_q + 4'd1;

        ovalid_d   = ovalid_q && !oready;
        oword_d    = oword_q;
        oidx_d     = oidx_q;
        olastblk_d = olastblk_q;
        oid_d      = oid_q;
        olen_d     = olen_q;
        if (emit_c) begin
            ovalid_d   = 1'b1;
            oword_d    = word_c;
            oidx_d     = widx_q;
            olastblk_d = lastblk_c;
            oid_d      = id_d;
            olen_d     = len_out_c;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wbuf_q     <= '0;
            pos_q      <= '0;
            widx_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            first_q    <= 1'b1;
            pad80_q    <= 1'b0;
            ovalid_q   <= 1'b0;
            oword_q    <= '0;
            oidx_q     <= '0;
            olastblk_q <= 1'b0;
            oid_q      <= '0;
            olen_q     <= '0;
        end else begin
            wbuf_q     <= wbuf_d;
            pos_q      <= pos_d;
            widx_q     <= widx_d;
            len_q      <= len_d;
            id_q       <= id_d;
            first_q    <= first_d;
            pad80_q    <= pad80_d;
            ovalid_q   <= ovalid_d;
            oword_q    <= oword_d;
            oidx_q     <= oidx_d;
            olastblk_q <= olastblk_d;
            oid_q      <= oid_d;
            olen_q     <= olen_d;
        end
    end

    assign ovalid   = ovalid_q;
    assign oword    = oword_q;
    assign oidx     = oidx_q;
    assign olastblk = olastblk_q;
    assign oid      = oid_q;
    assign olen     = olen_q;

endmodule
